buffered_printer: RTL and testbench

//   Printer model with an input FIFO. It sits directly downstream of the POC on the tr/pd/rdy link.
//   POC bursts characters into the FIFO while a print engine drains them, one per fixed print time.

---
 rtl/poc_pkg.sv | 14 +
 rtl/buffered_printer_if.sv | 27 ++
 rtl/printer_fifo.sv | 65 ++++++
 rtl/buffered_printer.sv | 101 ++++++++++
 tb/tb_buffered_printer.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/poc_pkg.sv
// Shared types and defaults for the buffered printer and its FIFO.
package poc_pkg;

  localparam int DATA_W           = 8;
  localparam int DEF_DEPTH        = 8;
  localparam int DEF_ADDR_W       = 3;
  localparam int DEF_PRINT_CYCLES = 4;

  typedef enum logic {
    PR_IDLE  = 1'b0,
    PR_PRINT = 1'b1
  } pr_state_t;

endpackage

// File: rtl/buffered_printer_if.sv
// POC-to-printer link plus printer status outputs.
interface buffered_printer_if
  import poc_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              i_tr;
  logic [DATA_W-1:0] i_pd;
  logic              o_rdy;
  logic [DATA_W-1:0] o_data;
  logic              o_data_valid;
  logic              o_busy;
  logic [ADDR_W:0]   o_level;
  logic              o_overrun;

  modport slave (
    input  i_tr, i_pd,
    output o_rdy, o_data, o_data_valid, o_busy, o_level, o_overrun
  );

  modport master (
    output i_tr, i_pd,
    input  o_rdy, o_data, o_data_valid, o_busy, o_level, o_overrun
  );

endinterface

// File: rtl/printer_fifo.sv
// Synchronous FIFO with registered storage; head is visible combinationally on o_dout.
module printer_fifo
  import poc_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_din,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              push_en, pop_en;

  assign o_full  = (count_q == FULL_CNT);
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_dout  = mem_q[rd_ptr_q];

  // Guard here too so the count can never leave 0..DEPTH.
  assign push_en = i_push && !o_full;
  assign pop_en  = i_pop  && !o_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_en) mem_q[wr_ptr_q] <= i_din;
  end

endmodule

// File: rtl/buffered_printer.sv
// Printer model: input FIFO drained by a print engine, one character per PRINT_CYCLES+1 cycles.
// o_rdy comes from the registered FIFO count only, so there is no path from i_tr.
module buffered_printer
  import poc_pkg::*;
#(
  parameter int DEPTH        = DEF_DEPTH,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int PRINT_CYCLES = DEF_PRINT_CYCLES
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  buffered_printer_if.slave   bus
);

  localparam int CNT_W = (PRINT_CYCLES > 1) ? $clog2(PRINT_CYCLES) : 1;

  pr_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] char_q, char_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              dv_q, dv_d;
  logic              overrun_q, overrun_d;

  logic              fifo_push, fifo_pop;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full, fifo_empty;
  logic [ADDR_W:0]   fifo_count;

  assign fifo_push = bus.i_tr && bus.o_rdy;

  printer_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (fifo_push),
    .i_pop   (fifo_pop),
    .i_din   (bus.i_pd),
    .o_dout  (fifo_dout),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    char_d    = char_q;
    data_d    = data_q;
    dv_d      = 1'b0;
    fifo_pop  = 1'b0;
    overrun_d = overrun_q || (bus.i_tr && !bus.o_rdy);
    case (state_q)
      PR_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          char_d   = fifo_dout;
          cnt_d    = CNT_W'(PRINT_CYCLES - 1);
          state_d  = PR_PRINT;
        end
      end
      PR_PRINT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          data_d  = char_q;
          dv_d    = 1'b1;
          state_d = PR_IDLE;
        end
      end
      default: state_d = PR_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= PR_IDLE;
      cnt_q     <= '0;
      char_q    <= '0;
      data_q    <= '0;
      dv_q      <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      char_q    <= char_d;
      data_q    <= data_d;
      dv_q      <= dv_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.o_rdy        = !fifo_full;
  assign bus.o_data       = data_q;
  assign bus.o_data_valid = dv_q;
  assign bus.o_busy       = (state_q == PR_PRINT);
  assign bus.o_level      = fifo_count;
  assign bus.o_overrun    = overrun_q;

endmodule

// File: tb/tb_buffered_printer.sv
// Scoreboard bench for buffered_printer with a timing-level reference model.
module tb_buffered_printer;
  import poc_pkg::*;

  localparam int PC    = DEF_PRINT_CYCLES;
  localparam int DEPTH = DEF_DEPTH;

  typedef struct {
    logic [7:0] d;
    int         t;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   dv_cnt   = 0;
  int   last_dv_seen = -1;

  // Reference model: per character, the cycle it was pushed, popped and printed.
  int   push_c[$];
  int   pop_c[$];
  int   dv_c[$];
  int   last_dv = -1000;
  bit   ovr_m   = 1'b0;
  exp_t exp_q[$];

  buffered_printer_if bus ();

  buffered_printer dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int occ_at(input int c);
    int n = 0;
    foreach (push_c[i]) if (push_c[i] < c) n++;
    foreach (pop_c[i])  if (pop_c[i]  < c) n--;
    return n;
  endfunction

  function automatic int busy_at(input int c);
    foreach (pop_c[i]) if (pop_c[i] < c && c < dv_c[i]) return 1;
    return 0;
  endfunction

  // The engine can only take a character the cycle after it arrives, and only
  // once it is back in IDLE, which is the cycle the previous print is announced.
  task automatic model_push(input logic [7:0] d, input int c);
    int p;
    exp_t e;
    p = (c + 1 > last_dv) ? c + 1 : last_dv;
    last_dv = p + 1 + PC;
    push_c.push_back(c);
    pop_c.push_back(p);
    dv_c.push_back(last_dv);
    e.d = d;
    e.t = last_dv;
    exp_q.push_back(e);
  endtask

  task automatic model_clear();
    push_c.delete();
    pop_c.delete();
    dv_c.delete();
    exp_q.delete();
    last_dv = -1000;
    ovr_m   = 1'b0;
  endtask

  // mode 0: drive as asked; 1: only push when there is room; 2: send 8'hFF when full
  task automatic step(input int mode, input bit tr_v, input logic [7:0] pd_v);
    int occ;
    bit t;
    logic [7:0] d;
    @(posedge clk);
    #1;
    occ = occ_at(cyc);
    check("level",   int'(bus.o_level),   occ);
    check("rdy",     int'(bus.o_rdy),     int'(occ < DEPTH));
    check("busy",    int'(bus.o_busy),    busy_at(cyc));
    check("overrun", int'(bus.o_overrun), int'(ovr_m));
    t = tr_v;
    d = pd_v;
    if (mode == 1 && occ >= DEPTH) t = 1'b0;
    if (mode == 2 && occ >= DEPTH) d = 8'hFF;
    bus.i_tr = t;
    bus.i_pd = d;
    if (t) begin
      if (occ < DEPTH) model_push(d, cyc);
      else             ovr_m = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 1'b0, 8'h00);
  endtask

  task automatic check_reset_outputs();
    check("rst_rdy",     int'(bus.o_rdy),        1);
    check("rst_data",    int'(bus.o_data),       0);
    check("rst_dv",      int'(bus.o_data_valid), 0);
    check("rst_busy",    int'(bus.o_busy),       0);
    check("rst_level",   int'(bus.o_level),      0);
    check("rst_overrun", int'(bus.o_overrun),    0);
  endtask

  task automatic do_reset(input bit exp_busy);
    @(posedge clk);
    #1;
    if (exp_busy) check("busy_before_reset", int'(bus.o_busy), 1);
    rst_n    = 1'b0;
    bus.i_tr = 1'b0;
    model_clear();
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: every print must match the next expected character and cycle.
  always @(negedge clk) begin
    if (bus.o_data_valid) begin
      dv_cnt++;
      last_dv_seen = cyc;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_print: got data %0h, expected no print (cycle %0d)",
                 bus.o_data, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("print_data",  int'(bus.o_data), int'(e.d));
        check("print_cycle", cyc,              e.t);
      end
    end
  end

  initial begin
    int t0;
    int dv_before;
    bus.i_tr = 1'b0;
    bus.i_pd = 8'h00;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;

    // Single character: printed six cycles after the push cycle.
    step(0, 1'b1, 8'h41);
    t0 = cyc;
    idle(12);
    check("single_latency", last_dv_seen, t0 + 6);
    check("single_data",    int'(bus.o_data), 8'h41);

    // Back-to-back burst of eight.
    for (int i = 0; i < 8; i++) step(0, 1'b1, 8'(8'h30 + i));
    idle(45);

    // Keep pushing until full; rejected characters are 8'hFF and must never print.
    for (int i = 0; i < 14; i++) step(2, 1'b1, 8'(8'h50 + i));
    idle(1);
    check("overrun_sticky", int'(bus.o_overrun), 1);

    // Refill whenever a slot frees up: level bounces between 7 and 8.
    for (int i = 0; i < 25; i++) step(1, 1'b1, 8'(8'h60 + i));
    idle(70);

    // Reset while printing with characters still queued.
    idle(2);
    for (int i = 0; i < 3; i++) step(0, 1'b1, 8'(8'h70 + i));
    do_reset(1'b1);
    dv_before = dv_cnt;
    idle(30);
    check("no_print_after_reset", dv_cnt, dv_before);

    // Twenty characters at one per five cycles: pointers wrap repeatedly.
    for (int i = 0; i < 20; i++) begin
      step(0, 1'b1, 8'($urandom));
      idle(4);
    end
    idle(10);

    // Random traffic including overruns.
    for (int i = 0; i < 300; i++)
      step(int'($urandom_range(0, 2)), ($urandom_range(0, 2) == 0), 8'($urandom));
    idle(60);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
